// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter with bus registers and a completion interrupt.
// Define PS2_TX_RETRY_EN to retry once automatically on NACK or timeout.
module ps2_host_tx #(
  parameter logic [7:0] BASE_ADDR = 8'hA4,
  parameter int INHIBIT_CYCLES = 6000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       CLK,
  input  logic       RESET,
  inout  wire  [7:0] BUS_DATA,
  input  logic [7:0] BUS_ADDR,
  input  logic       BUS_WE,
  output logic       BUS_INTERRUPT_RAISE,
  input  logic       BUS_INTERRUPT_ACK,
  input  logic       CLK_MOUSE_IN,
  input  logic       DATA_MOUSE_IN,
  output logic       CLK_MOUSE_OE,
  output logic       DATA_MOUSE_OE,
  output logic       TX_BUSY
);
`ifdef PS2_TX_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif
  localparam int CW = $clog2((TIMEOUT_CYCLES > INHIBIT_CYCLES ? TIMEOUT_CYCLES : INHIBIT_CYCLES) + 1);
  typedef enum logic [2:0] {IDLE, INHIBIT, SEND, WAIT_IDLE, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0] n, n_n;
  logic [7:0] tx_byte, rd_data, status;
  logic [1:0] clk_s, data_s;
  logic clk_d, parity, data_oe, doe_n, ack_ok, error, overrun, retried, irq, rd_en;
  logic fall, wr, wr_ok, nack, timeout, set_ack, set_err, set_irq, retry_go;
  assign fall = clk_d & ~clk_s[1];
  assign wr = BUS_WE && BUS_ADDR == BASE_ADDR;
  assign wr_ok = wr && state == IDLE;
  assign nack = state == SEND && fall && n == 4'd10 && data_s[1];
  assign timeout = (state == SEND || state == WAIT_IDLE) && cnt == CW'(TIMEOUT_CYCLES - 1);
  assign status = {3'b0, retried, overrun, error, ack_ok, TX_BUSY};
  assign TX_BUSY = state != IDLE;
  assign CLK_MOUSE_OE = state == INHIBIT;
  assign DATA_MOUSE_OE = data_oe;
  assign BUS_INTERRUPT_RAISE = irq;
  assign BUS_DATA = rd_en ? rd_data : 8'bz;
  always_comb begin
    state_n = state;
    cnt_n = cnt + CW'(1);
    n_n = n;
    doe_n = data_oe;
    set_ack = 1'b0;
    set_err = 1'b0;
    set_irq = 1'b0;
    retry_go = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        doe_n = 1'b0;
        if (wr) state_n = INHIBIT;
      end
      INHIBIT: begin
        n_n = '0;
        doe_n = 1'b0;
        if (cnt == CW'(INHIBIT_CYCLES - 1)) begin
          state_n = SEND;
          cnt_n = '0;
          doe_n = 1'b1;
        end
      end
      SEND: if (fall) begin
        n_n = n + 4'd1;
        doe_n = n < 4'd8 ? ~tx_byte[n[2:0]] : n == 4'd8 ? ~parity : 1'b0;
        if (n == 4'd10) begin
          state_n = WAIT_IDLE;
          set_ack = ~data_s[1];
        end
      end
      WAIT_IDLE: if (clk_s[1] && data_s[1]) state_n = DONE;
      DONE: begin
        set_irq = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // A failure either restarts the request once or is reported
    if ((nack || timeout) && RETRY && !retried) begin
      retry_go = 1'b1;
      state_n = INHIBIT;
      cnt_n = '0;
      doe_n = 1'b0;
    end else if (timeout) begin
      set_err = 1'b1;
      set_irq = 1'b1;
      state_n = IDLE;
      doe_n = 1'b0;
    end else if (nack) set_err = 1'b1;
  end
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      clk_s <= 2'b11;
      data_s <= 2'b11;
      clk_d <= 1'b1;
      state <= IDLE;
      cnt <= '0;
      n <= '0;
      data_oe <= 1'b0;
      tx_byte <= '0;
      parity <= 1'b0;
      ack_ok <= 1'b0;
      error <= 1'b0;
      overrun <= 1'b0;
      retried <= 1'b0;
      irq <= 1'b0;
      rd_en <= 1'b0;
      rd_data <= '0;
    end else begin
      clk_s <= {clk_s[0], CLK_MOUSE_IN};
      data_s <= {data_s[0], DATA_MOUSE_IN};
      clk_d <= clk_s[1];
      state <= state_n;
      cnt <= cnt_n;
      n <= n_n;
      data_oe <= doe_n;
      irq <= set_irq | (irq & ~BUS_INTERRUPT_ACK);
      rd_en <= !BUS_WE && BUS_ADDR == BASE_ADDR + 8'd1;
      rd_data <= status;
      if (wr_ok) begin
        tx_byte <= BUS_DATA;
        parity <= ~^BUS_DATA;
        ack_ok <= 1'b0;
        error <= 1'b0;
        overrun <= 1'b0;
        retried <= 1'b0;
      end else begin
        overrun <= overrun | wr;
        ack_ok <= ack_ok | set_ack;
        error <= error | set_err;
        retried <= retried | retry_go;
      end
    end
  end
endmodule
